// File: rtl/gray_count_sched_if.sv
// Bundle between the requester logic, the shared gray_count instance and the
// scheduler. The scheduler takes the slave side; whoever owns the requesters
// and the counter takes the master side.
interface gray_count_sched_if #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
);
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] target;
   logic [WIDTH-1:0]      gray_in;
   logic                  cnt_enable;
   logic                  cnt_clear;
   logic [NREQ-1:0]       grant;
   logic                  busy;
   logic [NREQ-1:0]       done;
   logic                  err;

   modport master (
      output req, target, gray_in,
      input  cnt_enable, cnt_clear, grant, busy, done, err
   );

   modport slave (
      input  req, target, gray_in,
      output cnt_enable, cnt_clear, grant, busy, done, err
   );
endinterface

// File: rtl/gray_count_sched.sv
// Round-robin scheduler sharing one gray_count among NREQ requesters.
// A granted requester gets a counter clear, then the counter is enabled until
// its gray output equals the gray code of the latched binary target. A
// watchdog ends runs that never match; dropping req aborts a run silently.
module gray_count_sched #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
) (
   input  logic            clk,
   input  logic            reset,
   gray_count_sched_if.slave bus
);

   localparam int PTR_W = $clog2(NREQ);
   // Watchdog needs to hold 2^WIDTH, so two spare bits are plenty.
   localparam int WD_W  = WIDTH + 2;
   // Value of the watchdog while the (2^WIDTH+1)-th enabled cycle is under way.
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(1) << WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      RUN,
      DONE
   } state_t;

   state_t            state_reg,  state_next;
   logic [NREQ-1:0]   grant_reg,  grant_next;
   logic [PTR_W-1:0]  ptr_reg,    ptr_next;
   logic [WIDTH-1:0]  tgt_reg,    tgt_next;
   logic [WD_W-1:0]   wdog_reg,   wdog_next;
   logic              err_reg,    err_next;

   logic              pick_valid;
   logic [PTR_W-1:0]  pick_idx;
   logic [NREQ-1:0]   pick_onehot;
   logic [WIDTH-1:0]  tgt_gray;
   logic              owner_req;
   logic              match;
   logic              wd_hit;
   logic              cnt_enable_c;
   logic              cnt_clear_c;
   logic [NREQ-1:0]   done_c;

   assign tgt_gray    = tgt_reg ^ (tgt_reg >> 1);
   assign owner_req   = |(bus.req & grant_reg);
   assign match       = (bus.gray_in == tgt_gray);
   assign wd_hit      = (wdog_reg == WD_LAST);
   assign pick_onehot = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;

   // Round-robin search: first requester above the last owner, wrapping.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!pick_valid && bus.req[(int'(ptr_reg) + k) % NREQ]) begin
            pick_valid = 1'b1;
            pick_idx   = PTR_W'((int'(ptr_reg) + k) % NREQ);
         end
      end
   end

   // Next-state and counter-control decode; match beats watchdog beats abort.
   always_comb begin
      state_next   = state_reg;
      grant_next   = grant_reg;
      ptr_next     = ptr_reg;
      tgt_next     = tgt_reg;
      wdog_next    = wdog_reg;
      err_next     = err_reg;
      cnt_enable_c = 1'b0;
      cnt_clear_c  = 1'b0;
      done_c       = '0;
      case (state_reg)
         IDLE: begin
            if (pick_valid) begin
               grant_next = pick_onehot;
               tgt_next   = bus.target[int'(pick_idx)*WIDTH +: WIDTH];
               ptr_next   = pick_idx;
               err_next   = 1'b0;
               state_next = CLEAR;
            end
         end
         CLEAR: begin
            cnt_clear_c = 1'b1;
            wdog_next   = '0;
            if (!owner_req) begin
               grant_next = '0;
               state_next = IDLE;
            end else begin
               state_next = RUN;
            end
         end
         RUN: begin
            // No step on the abort cycle, so the counter freezes where it was.
            cnt_enable_c = !match && owner_req;
            if (cnt_enable_c) begin
               wdog_next = wdog_reg + WD_W'(1);
            end
            if (match) begin
               state_next = DONE;
            end else if (wd_hit) begin
               err_next   = 1'b1;
               state_next = DONE;
            end else if (!owner_req) begin
               grant_next = '0;
               state_next = IDLE;
            end
         end
         DONE: begin
            done_c     = grant_reg;
            grant_next = '0;
            state_next = IDLE;
         end
         default: begin
            grant_next = '0;
            state_next = IDLE;
         end
      endcase
   end

   // State registers; pointer starts at the top so requester 0 wins first.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         grant_reg <= '0;
         ptr_reg   <= PTR_W'(NREQ - 1);
         tgt_reg   <= '0;
         wdog_reg  <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         grant_reg <= grant_next;
         ptr_reg   <= ptr_next;
         tgt_reg   <= tgt_next;
         wdog_reg  <= wdog_next;
         err_reg   <= err_next;
      end
   end

   assign bus.grant      = grant_reg;
   assign bus.busy       = (state_reg != IDLE);
   assign bus.err        = err_reg;
   assign bus.cnt_enable = cnt_enable_c;
   assign bus.cnt_clear  = cnt_clear_c;
   assign bus.done       = done_c;

endmodule

// File: tb/tb_gray_count_sched.sv
// Directed bench for gray_count_sched with a behavioural gray_count attached.
module tb_gray_count_sched;

   localparam int WIDTH = 8;
   localparam int NREQ  = 4;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic       stuck = 1'b0;
   logic [7:0] bin   = 8'd0;
   int         n_total = 0;
   int         n_pass  = 0;
   int         n_fail  = 0;

   gray_count_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

   gray_count_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Shared gray counter: synchronous clear has priority over enable.
   always @(posedge clk) begin
      if (bus.cnt_clear)       bin <= 8'd0;
      else if (bus.cnt_enable) bin <= bin + 8'd1;
   end

   assign bus.gray_in = stuck ? 8'h00 : (bin ^ (bin >> 1));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called in the IDLE cycle where req is already up (cycle 0); returns in
   // the idle cycle after the done pulse (cycle t+4).
   task automatic run_check(input string tag, input logic [3:0] owner, input int t,
                            input logic [7:0] gray_end);
      int en;
      tick();
      check({tag, "_grant"}, bus.grant, owner);
      check({tag, "_clear"}, bus.cnt_clear, 1'b1);
      en = 0;
      repeat (t + 1) begin
         tick();
         en += int'(bus.cnt_enable);
      end
      check({tag, "_en_cycles"}, en, t);
      check({tag, "_match_en"}, bus.cnt_enable, 1'b0);
      check({tag, "_gray"}, bus.gray_in, gray_end);
      tick();
      check({tag, "_done"}, bus.done, owner);
      check({tag, "_done_grant"}, bus.grant, owner);
      check({tag, "_err"}, bus.err, 1'b0);
      tick();
      check({tag, "_idle_busy"}, bus.busy, 1'b0);
      check({tag, "_idle_grant"}, bus.grant, 4'b0000);
      check({tag, "_idle_done"}, bus.done, 4'b0000);
   endtask

   initial begin
      int en;
      int n;
      bus.req    = 4'b1111;
      bus.target = '0;

      // 1: everything quiet while reset is held, then requester 0 wins first
      repeat (3) begin
         tick();
         check("rst_outs", {bus.grant, bus.busy, bus.cnt_enable, bus.cnt_clear,
                            bus.done, bus.err}, 12'h000);
      end
      reset = 1'b1;
      tick();
      check("first_grant", bus.grant, 4'b0001);
      check("first_clear", bus.cnt_clear, 1'b1);
      bus.req = 4'b0000;
      tick();
      check("abort_clear_grant", bus.grant, 4'b0000);
      check("abort_clear_busy", bus.busy, 1'b0);

      // 2: single run to 5, counter ends on gray(5)=07
      bus.target = {8'd0, 8'd0, 8'd0, 8'd5};
      bus.req    = 4'b0001;
      run_check("t2", 4'b0001, 5, 8'h07);
      bus.req = 4'b0000;
      tick();
      check("t2_no_regrant", bus.grant, 4'b0000);

      // 3: two requesters alternate; pointer was left at 0 so 1 goes first
      bus.target = {8'd0, 8'd0, 8'd2, 8'd3};
      bus.req    = 4'b0011;
      run_check("t3a", 4'b0010, 2, 8'h03);
      run_check("t3b", 4'b0001, 3, 8'h02);
      run_check("t3c", 4'b0010, 2, 8'h03);
      run_check("t3d", 4'b0001, 3, 8'h02);
      bus.req = 4'b0000;

      // 4: target 0 matches immediately
      bus.target = {8'd0, 8'd0, 8'd0, 8'd0};
      bus.req    = 4'b0100;
      run_check("t4", 4'b0100, 0, 8'h00);
      bus.req = 4'b0000;

      // 5: abort after 10 enabled cycles, counter frozen at gray(10)=0F
      bus.target = {8'd200, 8'd0, 8'd0, 8'd0};
      bus.req    = 4'b1000;
      tick();
      check("t5_grant", bus.grant, 4'b1000);
      check("t5_clear", bus.cnt_clear, 1'b1);
      en = 0;
      repeat (10) begin
         tick();
         en += int'(bus.cnt_enable);
      end
      check("t5_en_cycles", en, 10);
      tick();
      bus.req = 4'b0000;
      #1;
      check("t5_abort_en", bus.cnt_enable, 1'b0);
      check("t5_abort_done", bus.done, 4'b0000);
      tick();
      check("t5_idle_grant", bus.grant, 4'b0000);
      check("t5_idle_busy", bus.busy, 1'b0);
      check("t5_idle_done", bus.done, 4'b0000);
      check("t5_frozen", bus.gray_in, 8'h0F);
      tick();
      check("t5_frozen2", bus.gray_in, 8'h0F);

      // 6: stuck counter trips the watchdog after 257 enabled cycles
      stuck      = 1'b1;
      bus.target = {8'd0, 8'd0, 8'd0, 8'd3};
      bus.req    = 4'b0001;
      tick();
      check("t6_grant", bus.grant, 4'b0001);
      check("t6_clear", bus.cnt_clear, 1'b1);
      tick();
      n = 0;
      while (bus.cnt_enable === 1'b1 && n < 300) begin
         n++;
         tick();
      end
      check("t6_en_cycles", n, 257);
      check("t6_done", bus.done, 4'b0001);
      check("t6_err", bus.err, 1'b1);
      bus.req = 4'b0000;
      tick();
      check("t6_err_held", bus.err, 1'b1);
      check("t6_idle_busy", bus.busy, 1'b0);
      bus.req = 4'b0010;
      tick();
      check("t6_regrant", bus.grant, 4'b0010);
      check("t6_err_clr", bus.err, 1'b0);
      tick();
      check("t6_zero_en", bus.cnt_enable, 1'b0);
      tick();
      check("t6_done2", bus.done, 4'b0010);
      check("t6_err2", bus.err, 1'b0);
      bus.req = 4'b0000;
      tick();

      // Reset mid-run: outputs drop at once, pointer back to the top
      stuck      = 1'b0;
      bus.target = {8'd0, 8'd0, 8'd0, 8'd200};
      bus.req    = 4'b0001;
      repeat (4) tick();
      check("mid_busy", bus.busy, 1'b1);
      #3;
      reset = 1'b0;
      #1;
      check("mid_rst_outs", {bus.grant, bus.busy, bus.cnt_enable, bus.cnt_clear,
                             bus.done, bus.err}, 12'h000);
      bus.req = 4'b1111;
      tick();
      reset = 1'b1;
      tick();
      check("mid_rst_grant", bus.grant, 4'b0001);
      bus.req = 4'b0000;
      tick();
      check("mid_rst_idle", bus.busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
